// File: rtl/matmul_top_controller.sv
// ---------------------------------------------------------------------------
// matmul_top_controller
//
// Self-contained N x N unsigned matrix-multiply engine, C = A x B.
// Operands live in MEM_A / MEM_B and results go to MEM_C. All three are
// row-major (addr = row*N + col). They have no external data ports and are
// loaded and read by hierarchical reference. One multiply-accumulate is
// performed per clock. done rises N^3+3 cycles after the edge that samples
// start.
//
// Ports
//   clk   : rising-edge clock
//   rst   : asynchronous, active-high reset (memories are not cleared)
//   start : single-cycle request to begin a full multiply (IDLE or DONE)
//   done  : high while MEM_C holds the complete product
//
// N must be a power of two, with AW = 2*log2(N). Addresses are formed by
// concatenating the row and column counters.
// ---------------------------------------------------------------------------

// Simple single-port-write / single-port-read memory with a registered read.
// The array name is fixed because benches reach it hierarchically.
module mm_mem #(
   parameter int DEPTH = 4096,
   parameter int W     = 8,
   parameter int AW    = 12
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] array [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         array[waddr] <= wdata;
      end
      rdata <= array[raddr];
   end

endmodule

// state | meaning
// IDLE  | waiting for start, counters at zero, done low
// RUN   | one A/B address pair issued per cycle, k fastest, then j, then i
// DRAIN | all addresses issued, waiting for the final C write
// DONE  | MEM_C complete, done high; start restarts RUN
module matmul_top_controller #(
   parameter int N  = 64,
   parameter int DW = 8,
   parameter int OW = 22,
   parameter int AW = 12
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   output logic done
);

   localparam int CW    = AW / 2;
   localparam int DEPTH = N * N;
   localparam logic [CW-1:0] CNT_MAX = CW'(N - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t state, state_nxt;

   logic [CW-1:0] i_cnt, j_cnt, k_cnt;
   logic          issue;
   logic          last_issue;

   logic [AW-1:0] addr_a, addr_b;
   logic [DW-1:0] rd_a, rd_b;
   logic [2*DW-1:0] prod;

   // Stage 1: memory read in flight
   logic          s1_vld;
   logic          s1_k0;
   logic          s1_klast;
   logic [AW-1:0] s1_addr_c;

   // Stage 2: accumulator, and the write request for a completed sum
   logic [OW-1:0] acc;
   logic          s2_wr;
   logic [AW-1:0] s2_addr_c;

   // Set for one cycle after each C write. DRAIN uses it to spot the final
   // write once nothing else remains in the pipe.
   logic          wr_seen;

   logic [OW-1:0] c_rdata;

   assign last_issue = (i_cnt == CNT_MAX) && (j_cnt == CNT_MAX) && (k_cnt == CNT_MAX);
   assign addr_a     = {i_cnt, k_cnt};
   assign addr_b     = {k_cnt, j_cnt};
   assign prod       = rd_a * rd_b;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      issue     = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = RUN;
            end
         end
         RUN: begin
            issue = 1'b1;
            if (last_issue) begin
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (wr_seen && !s1_vld && !s2_wr) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            done = 1'b1;
            if (start) begin
               state_nxt = RUN;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // The counters wrap back to zero on the last issue, so they are already
   // cleared for the next run when RUN is left.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         i_cnt <= '0;
         j_cnt <= '0;
         k_cnt <= '0;
      end else if (issue) begin
         if (k_cnt == CNT_MAX) begin
            k_cnt <= '0;
            if (j_cnt == CNT_MAX) begin
               j_cnt <= '0;
               if (i_cnt == CNT_MAX) begin
                  i_cnt <= '0;
               end else begin
                  i_cnt <= i_cnt + 1'b1;
               end
            end else begin
               j_cnt <= j_cnt + 1'b1;
            end
         end else begin
            k_cnt <= k_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_vld    <= 1'b0;
         s1_k0     <= 1'b0;
         s1_klast  <= 1'b0;
         s1_addr_c <= '0;
      end else begin
         s1_vld    <= issue;
         s1_k0     <= (k_cnt == '0);
         s1_klast  <= (k_cnt == CNT_MAX);
         s1_addr_c <= {i_cnt, j_cnt};
      end
   end

   // The k==0 term loads rather than adds, so a new dot product needs no
   // separate clear cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc       <= '0;
         s2_wr     <= 1'b0;
         s2_addr_c <= '0;
         wr_seen   <= 1'b0;
      end else begin
         if (s1_vld) begin
            if (s1_k0) begin
               acc <= OW'(prod);
            end else begin
               acc <= acc + OW'(prod);
            end
         end
         s2_wr     <= s1_vld && s1_klast;
         s2_addr_c <= s1_addr_c;
         wr_seen   <= s2_wr;
      end
   end

   mm_mem #(.DEPTH(DEPTH), .W(DW), .AW(AW)) MEM_A (
      .clk   (clk),
      .we    (1'b0),
      .waddr ('0),
      .wdata ('0),
      .raddr (addr_a),
      .rdata (rd_a)
   );

   mm_mem #(.DEPTH(DEPTH), .W(DW), .AW(AW)) MEM_B (
      .clk   (clk),
      .we    (1'b0),
      .waddr ('0),
      .wdata ('0),
      .raddr (addr_b),
      .rdata (rd_b)
   );

   // The read port of MEM_C is not used by the engine. Results are taken out
   // hierarchically.
   mm_mem #(.DEPTH(DEPTH), .W(OW), .AW(AW)) MEM_C (
      .clk   (clk),
      .we    (s2_wr),
      .waddr (s2_addr_c),
      .wdata (acc),
      .raddr ('0),
      .rdata (c_rdata)
   );

endmodule

// File: tb/tb_matmul_top_controller.sv
// Bench for matmul_top_controller, built at N=8 to keep run length short.
module tb_matmul_top_controller;

   localparam int N   = 8;
   localparam int DW  = 8;
   localparam int OW  = 22;
   localparam int AW  = 6;
   localparam int NN  = N * N;
   localparam int LAT = N * N * N + 3;
   localparam logic [OW-1:0] SENT = 22'h2AAAAA;

   logic clk = 1'b0;
   logic rst;
   logic start;
   logic done;

   int checks   = 0;
   int failures = 0;

   int            ga [NN];
   int            gb [NN];
   logic [OW-1:0] gc [NN];

   always #5 clk = ~clk;

   matmul_top_controller #(.N(N), .DW(DW), .OW(OW), .AW(AW)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .done  (done)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Load the operands into the DUT, optionally fill C with a sentinel, and
   // build the expected product.
   task automatic load_mems(input bit clear_c);
      int s;
      for (int a = 0; a < NN; a++) begin
         dut.MEM_A.array[a] = 8'(ga[a]);
         dut.MEM_B.array[a] = 8'(gb[a]);
         if (clear_c) dut.MEM_C.array[a] = SENT;
      end
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            s = 0;
            for (int k = 0; k < N; k++) s += ga[i*N+k] * gb[k*N+j];
            gc[i*N+j] = OW'(s);
         end
      end
   endtask

   task automatic compare_c(input string tag);
      int errs;
      errs = 0;
      for (int a = 0; a < NN; a++) begin
         if (dut.MEM_C.array[a] !== gc[a]) errs++;
      end
      check_eq({tag, "_errs"}, errs, 0);
      check_eq({tag, "_c0"}, 32'(dut.MEM_C.array[0]), 32'(gc[0]));
      check_eq({tag, "_clast"}, 32'(dut.MEM_C.array[NN-1]), 32'(gc[NN-1]));
   endtask

   // Pulse start, then count edges until done. Extra start pulses are
   // sampled at cycles poke1+1 / poke2+1 and must be ignored.
   task automatic run_and_time(input string tag, input int poke1, input int poke2);
      int cyc;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check_eq({tag, "_drop"}, 32'(done), 0);
      cyc = 0;
      while (!done && cyc < LAT + 200) begin
         if (cyc == poke1 || cyc == poke2) begin
            @(negedge clk);
            start = 1'b1;
         end
         @(posedge clk);
         #1;
         start = 1'b0;
         cyc++;
      end
      check_eq({tag, "_lat"}, cyc, LAT);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_done", 32'(done), 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check_eq("idle_done", 32'(done), 0);

      // All ones: every entry is N
      for (int a = 0; a < NN; a++) begin ga[a] = 1; gb[a] = 1; end
      load_mems(1'b1);
      run_and_time("ones", -1, -1);
      compare_c("ones");
      check_eq("ones_c5", 32'(dut.MEM_C.array[5]), 8);
      repeat (5) @(posedge clk);
      #1;
      check_eq("done_hold", 32'(done), 1);

      // Asynchronous reset while in DONE
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check_eq("rst_async_done", 32'(done), 0);
      @(negedge clk);
      rst = 1'b0;

      // Identity A, so C equals B
      for (int r = 0; r < N; r++) begin
         for (int c = 0; c < N; c++) begin
            ga[r*N+c] = (r == c) ? 1 : 0;
            gb[r*N+c] = ((r*N + c) * 3) % 256;
         end
      end
      load_mems(1'b1);
      run_and_time("ident", -1, -1);
      compare_c("ident");
      check_eq("ident_c9", 32'(dut.MEM_C.array[9]), 27);

      // Reset mid-run at cycle 100: entry e is written at edge 8e+10, so
      // entries 0..11 are written and entry 12 is not.
      load_mems(1'b1);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (99) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check_eq("midrst_done", 32'(done), 0);
      check_eq("midrst_kept", 32'(dut.MEM_C.array[11]), 33);
      check_eq("midrst_untouched", 32'(dut.MEM_C.array[12]), 32'(SENT));
      @(negedge clk);
      rst = 1'b0;
      run_and_time("rerun", -1, -1);
      compare_c("rerun");

      // All 255: largest sum, no wrap
      for (int a = 0; a < NN; a++) begin ga[a] = 255; gb[a] = 255; end
      load_mems(1'b1);
      run_and_time("max", -1, -1);
      compare_c("max");
      check_eq("max_c17", 32'(dut.MEM_C.array[17]), 520200);

      // Random operands
      for (int a = 0; a < NN; a++) begin
         ga[a] = int'($urandom_range(0, 255));
         gb[a] = int'($urandom_range(0, 255));
      end
      load_mems(1'b1);
      run_and_time("rand", -1, -1);
      compare_c("rand");

      // Extra start pulses during RUN and DRAIN are ignored
      load_mems(1'b1);
      run_and_time("ignore", 199, 512);
      compare_c("ignore");

      // Restart from DONE with a new B, leaving the old C in place
      for (int a = 0; a < NN; a++) gb[a] = int'($urandom_range(0, 255));
      load_mems(1'b0);
      run_and_time("newb", -1, -1);
      compare_c("newb");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
